// File: rtl/sa_ctrl_if.sv
// Requester-side signals for the station-address controller: Q-bus byte reads
// and the receive address-filter byte stream.
interface sa_ctrl_if;
  logic       bus_req;
  logic [2:0] bus_idx;
  logic       bus_ack;
  logic [7:0] bus_data;
  logic       flt_go;
  logic       flt_valid;
  logic [2:0] flt_idx;
  logic [7:0] flt_data;
  logic       flt_last;

  modport master (
    output bus_req, bus_idx, flt_go,
    input  bus_ack, bus_data, flt_valid, flt_idx, flt_data, flt_last
  );

  modport slave (
    input  bus_req, bus_idx, flt_go,
    output bus_ack, bus_data, flt_valid, flt_idx, flt_data, flt_last
  );
endinterface

// File: rtl/sa_ctrl.sv
// Station-address controller: checksums the ROM image after reset, then shares
// the (optionally overridden) address bytes between bus reads and the filter stream.
module sa_ctrl #(
  parameter int NBYTES = 6,
  parameter int CSW    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] sarom_q,
  sa_ctrl_if.slave    bif,
  input  logic        ovr_we,
  input  logic [2:0]  ovr_widx,
  input  logic [7:0]  ovr_wdata,
  input  logic        ovr_en,
  output logic        ready,
  output logic        sa_ok
);

  typedef enum logic [1:0] {S_CHECK, S_CMP, S_READY} state_t;

  state_t           state_q, state_d;
  logic [CSW-1:0]   sum_q, sum_d;
  logic [2:0]       ptr_q, ptr_d;
  logic             ready_q, ready_d;
  logic             sa_ok_q, sa_ok_d;
  logic             bus_ack_q, bus_ack_d;
  logic [7:0]       bus_data_q, bus_data_d;
  logic             pend_q, pend_d;
  logic             active_q, active_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             flt_valid_q, flt_valid_d;
  logic [2:0]       flt_idx_q, flt_idx_d;
  logic [7:0]       flt_data_q, flt_data_d;
  logic             flt_last_q, flt_last_d;
  logic [7:0]       ovr_q [NBYTES];
  logic [7:0]       ovr_d [NBYTES];

  logic [7:0]       rom_b [8];
  logic [7:0]       eff_b [8];
  logic             grant;
  logic             start;
  logic             beat;

  // State register and all datapath/control flops
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_CHECK;
      sum_q       <= '0;
      ptr_q       <= '0;
      ready_q     <= 1'b0;
      sa_ok_q     <= 1'b0;
      bus_ack_q   <= 1'b0;
      bus_data_q  <= '0;
      pend_q      <= 1'b0;
      active_q    <= 1'b0;
      cnt_q       <= '0;
      flt_valid_q <= 1'b0;
      flt_idx_q   <= '0;
      flt_data_q  <= '0;
      flt_last_q  <= 1'b0;
      for (int i = 0; i < NBYTES; i++) ovr_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      ptr_q       <= ptr_d;
      ready_q     <= ready_d;
      sa_ok_q     <= sa_ok_d;
      bus_ack_q   <= bus_ack_d;
      bus_data_q  <= bus_data_d;
      pend_q      <= pend_d;
      active_q    <= active_d;
      cnt_q       <= cnt_d;
      flt_valid_q <= flt_valid_d;
      flt_idx_q   <= flt_idx_d;
      flt_data_q  <= flt_data_d;
      flt_last_q  <= flt_last_d;
      for (int i = 0; i < NBYTES; i++) ovr_q[i] <= ovr_d[i];
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_CHECK: if (ptr_q == 3'(NBYTES - 1)) state_d = S_CMP;
      S_CMP:   state_d = S_READY;
      S_READY: state_d = S_READY;
      default: state_d = S_CHECK;
    endcase
  end

  // Output/datapath logic
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      rom_b[i] = sarom_q[8*i +: 8];
      eff_b[i] = rom_b[i];
    end
    // Override applies to address bytes only; checksum bytes always come from ROM
    for (int i = 0; i < NBYTES; i++) begin
      if (ovr_en) eff_b[i] = ovr_q[i];
      ovr_d[i] = ovr_q[i];
    end
    if (ovr_we && (32'(ovr_widx) < NBYTES)) ovr_d[ovr_widx] = ovr_wdata;

    sum_d       = sum_q;
    ptr_d       = ptr_q;
    ready_d     = ready_q;
    sa_ok_d     = sa_ok_q;
    bus_ack_d   = 1'b0;
    bus_data_d  = bus_data_q;
    active_d    = active_q;
    cnt_d       = cnt_q;
    flt_valid_d = 1'b0;
    flt_idx_d   = flt_idx_q;
    flt_data_d  = flt_data_q;
    flt_last_d  = 1'b0;
    pend_d      = pend_q | (bif.flt_go & ~active_q);

    grant = (state_q == S_READY) && bif.bus_req && !bus_ack_q;
    start = (state_q == S_READY) && pend_q && !active_q;
    beat  = (active_q || start) && !grant;

    case (state_q)
      S_CHECK: begin
        sum_d = sum_q + CSW'(rom_b[ptr_q]);
        ptr_d = ptr_q + 3'd1;
      end
      S_CMP: begin
        sa_ok_d = (sum_q == sarom_q[8*NBYTES +: CSW]);
        ready_d = 1'b1;
      end
      default: ;
    endcase

    if (grant) begin
      bus_ack_d  = 1'b1;
      bus_data_d = eff_b[bif.bus_idx];
    end

    if (start) begin
      active_d = 1'b1;
      pend_d   = 1'b0;
    end

    // A bus grant stalls the stream without advancing cnt
    if (beat) begin
      flt_valid_d = 1'b1;
      flt_idx_d   = cnt_q;
      flt_data_d  = eff_b[cnt_q];
      flt_last_d  = (cnt_q == 3'(NBYTES - 1));
      if (cnt_q == 3'(NBYTES - 1)) begin
        cnt_d    = '0;
        active_d = 1'b0;
      end else begin
        cnt_d = cnt_q + 3'd1;
      end
    end
  end

  assign ready         = ready_q;
  assign sa_ok         = sa_ok_q;
  assign bif.bus_ack   = bus_ack_q;
  assign bif.bus_data  = bus_data_q;
  assign bif.flt_valid = flt_valid_q;
  assign bif.flt_idx   = flt_idx_q;
  assign bif.flt_data  = flt_data_q;
  assign bif.flt_last  = flt_last_q;

endmodule

// File: tb/tb_sa_ctrl.sv
// Directed self-checking bench for sa_ctrl.
module tb_sa_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] sarom_q;
  logic        ovr_we;
  logic [2:0]  ovr_widx;
  logic [7:0]  ovr_wdata;
  logic        ovr_en;
  logic        ready;
  logic        sa_ok;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [63:0] ROM_GOOD = 64'h00CF_5634_122B_0008;
  localparam logic [63:0] ROM_BAD  = 64'h01CF_5634_122B_0008;

  logic [7:0] rom_bytes [6] = '{8'h08, 8'h00, 8'h2B, 8'h12, 8'h34, 8'h56};
  logic [7:0] ovr_bytes [6] = '{8'hAA, 8'hAB, 8'hAC, 8'hAD, 8'hAE, 8'hAF};

  sa_ctrl_if bif ();

  sa_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .sarom_q   (sarom_q),
    .bif       (bif.slave),
    .ovr_we    (ovr_we),
    .ovr_widx  (ovr_widx),
    .ovr_wdata (ovr_wdata),
    .ovr_en    (ovr_en),
    .ready     (ready),
    .sa_ok     (sa_ok)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sarom_q = ROM_GOOD;
    tick(); tick();
    n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready got %b want 0", ready); end
    n_cmp++; if (sa_ok !== 1'b0) begin n_bad++; $display("FAIL rst_sa_ok got %b want 0", sa_ok); end
    n_cmp++; if (bif.flt_valid !== 1'b0) begin n_bad++; $display("FAIL rst_flt_valid got %b want 0", bif.flt_valid); end
    n_cmp++; if (bif.bus_ack !== 1'b0) begin n_bad++; $display("FAIL rst_bus_ack got %b want 0", bif.bus_ack); end
    rst = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      tick();
      n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL early_ready edge %0d got %b want 0", e, ready); end
    end
    tick();
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL ready_edge7 got %b want 1", ready); end
    n_cmp++; if (sa_ok !== 1'b1) begin n_bad++; $display("FAIL sa_ok_good got %b want 1", sa_ok); end
  endtask

  task automatic test_bus();
    bif.bus_req = 1'b1; bif.bus_idx = 3'd2;
    for (int c = 1; c <= 4; c++) begin
      tick();
      n_cmp++; if (bif.bus_ack !== c[0]) begin n_bad++; $display("FAIL bus_ack_held cyc %0d got %b want %b", c, bif.bus_ack, c[0]); end
      if (c[0]) begin
        n_cmp++; if (bif.bus_data !== 8'h2B) begin n_bad++; $display("FAIL bus_data_idx2 got %h want 2b", bif.bus_data); end
      end
    end
    bif.bus_req = 1'b0;
    tick();
    bif.bus_req = 1'b1; bif.bus_idx = 3'd6;
    tick();
    bif.bus_req = 1'b0;
    n_cmp++; if (bif.bus_ack !== 1'b1) begin n_bad++; $display("FAIL bus_ack_idx6 got %b want 1", bif.bus_ack); end
    n_cmp++; if (bif.bus_data !== 8'hCF) begin n_bad++; $display("FAIL bus_data_idx6 got %h want cf", bif.bus_data); end
    tick();
  endtask

  task automatic test_stream();
    bif.flt_go = 1'b1;
    tick();
    bif.flt_go = 1'b0;
    n_cmp++; if (bif.flt_valid !== 1'b0) begin n_bad++; $display("FAIL stream_pre_valid got %b want 0", bif.flt_valid); end
    for (int i = 0; i < 6; i++) begin
      tick();
      n_cmp++; if (bif.flt_valid !== 1'b1) begin n_bad++; $display("FAIL stream_valid beat %0d got %b want 1", i, bif.flt_valid); end
      n_cmp++; if (bif.flt_idx !== 3'(i)) begin n_bad++; $display("FAIL stream_idx got %0d want %0d", bif.flt_idx, i); end
      n_cmp++; if (bif.flt_data !== rom_bytes[i]) begin n_bad++; $display("FAIL stream_data beat %0d got %h want %h", i, bif.flt_data, rom_bytes[i]); end
      n_cmp++; if (bif.flt_last !== (i == 5)) begin n_bad++; $display("FAIL stream_last beat %0d got %b want %b", i, bif.flt_last, (i == 5)); end
    end
    tick();
    n_cmp++; if (bif.flt_valid !== 1'b0) begin n_bad++; $display("FAIL stream_idle got %b want 0", bif.flt_valid); end
  endtask

  task automatic test_arbitration();
    bif.flt_go = 1'b1;
    tick();
    bif.flt_go = 1'b0;
    tick(); tick(); tick();
    n_cmp++; if (bif.flt_data !== 8'h2B || bif.flt_idx !== 3'd2) begin n_bad++; $display("FAIL arb_beat2 got idx %0d data %h want idx 2 data 2b", bif.flt_idx, bif.flt_data); end
    bif.bus_req = 1'b1; bif.bus_idx = 3'd0;
    tick();
    bif.bus_req = 1'b0;
    n_cmp++; if (bif.flt_valid !== 1'b0) begin n_bad++; $display("FAIL arb_stall_valid got %b want 0", bif.flt_valid); end
    n_cmp++; if (bif.flt_idx !== 3'd2) begin n_bad++; $display("FAIL arb_stall_idx got %0d want 2", bif.flt_idx); end
    n_cmp++; if (bif.bus_ack !== 1'b1 || bif.bus_data !== 8'h08) begin n_bad++; $display("FAIL arb_bus got ack %b data %h want ack 1 data 08", bif.bus_ack, bif.bus_data); end
    for (int i = 3; i < 6; i++) begin
      tick();
      n_cmp++; if (bif.flt_valid !== 1'b1 || bif.flt_idx !== 3'(i) || bif.flt_data !== rom_bytes[i]) begin
        n_bad++; $display("FAIL arb_resume got v %b idx %0d data %h want v 1 idx %0d data %h", bif.flt_valid, bif.flt_idx, bif.flt_data, i, rom_bytes[i]);
      end
    end
    n_cmp++; if (bif.flt_last !== 1'b1) begin n_bad++; $display("FAIL arb_last got %b want 1", bif.flt_last); end
    tick();
  endtask

  task automatic test_override();
    for (int i = 0; i < 6; i++) begin
      ovr_we = 1'b1; ovr_widx = 3'(i); ovr_wdata = ovr_bytes[i];
      tick();
    end
    ovr_widx = 3'd6; ovr_wdata = 8'h77;
    tick();
    ovr_we = 1'b0; ovr_en = 1'b1;
    bif.flt_go = 1'b1;
    tick();
    bif.flt_go = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_cmp++; if (bif.flt_valid !== 1'b1 || bif.flt_data !== ovr_bytes[i]) begin
        n_bad++; $display("FAIL ovr_stream beat %0d got v %b data %h want v 1 data %h", i, bif.flt_valid, bif.flt_data, ovr_bytes[i]);
      end
    end
    bif.bus_req = 1'b1; bif.bus_idx = 3'd7;
    tick();
    bif.bus_req = 1'b0;
    n_cmp++; if (bif.bus_ack !== 1'b1 || bif.bus_data !== 8'h00) begin n_bad++; $display("FAIL ovr_idx7 got ack %b data %h want ack 1 data 00", bif.bus_ack, bif.bus_data); end
    tick();
    bif.bus_req = 1'b1; bif.bus_idx = 3'd6;
    tick();
    bif.bus_req = 1'b0;
    n_cmp++; if (bif.bus_data !== 8'hCF) begin n_bad++; $display("FAIL ovr_idx6_rom got %h want cf", bif.bus_data); end
    tick();
    bif.bus_req = 1'b1; bif.bus_idx = 3'd3;
    ovr_we = 1'b1; ovr_widx = 3'd3; ovr_wdata = 8'h55;
    tick();
    bif.bus_req = 1'b0; ovr_we = 1'b0;
    n_cmp++; if (bif.bus_data !== 8'hAD) begin n_bad++; $display("FAIL ovr_same_cycle_old got %h want ad", bif.bus_data); end
    tick();
    bif.bus_req = 1'b1;
    tick();
    bif.bus_req = 1'b0;
    n_cmp++; if (bif.bus_data !== 8'h55) begin n_bad++; $display("FAIL ovr_new_value got %h want 55", bif.bus_data); end
    tick();
    ovr_en = 1'b0;
    bif.bus_req = 1'b1;
    tick();
    bif.bus_req = 1'b0;
    n_cmp++; if (bif.bus_data !== 8'h12) begin n_bad++; $display("FAIL ovr_disabled got %h want 12", bif.bus_data); end
    tick();
  endtask

  task automatic test_rst_mid_stream();
    bif.flt_go = 1'b1;
    tick();
    bif.flt_go = 1'b0;
    tick(); tick();
    n_cmp++; if (bif.flt_valid !== 1'b1) begin n_bad++; $display("FAIL midrst_pre got %b want 1", bif.flt_valid); end
    rst = 1'b1;
    tick();
    n_cmp++; if (bif.flt_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_valid got %b want 0", bif.flt_valid); end
    n_cmp++; if (ready !== 1'b0 || sa_ok !== 1'b0) begin n_bad++; $display("FAIL midrst_ready got ready %b sa_ok %b want 0 0", ready, sa_ok); end
    rst = 1'b0;
    for (int e = 0; e < 7; e++) tick();
    n_cmp++; if (ready !== 1'b1 || sa_ok !== 1'b1) begin n_bad++; $display("FAIL midrst_recheck got ready %b sa_ok %b want 1 1", ready, sa_ok); end
    n_cmp++; if (bif.flt_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_no_resume got %b want 0", bif.flt_valid); end
    tick();
    n_cmp++; if (bif.flt_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_no_resume2 got %b want 0", bif.flt_valid); end
  endtask

  task automatic test_bad_checksum();
    sarom_q = ROM_BAD;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int e = 0; e < 6; e++) tick();
    n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL bad_ready_early got %b want 0", ready); end
    tick();
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL bad_ready got %b want 1", ready); end
    n_cmp++; if (sa_ok !== 1'b0) begin n_bad++; $display("FAIL bad_sa_ok got %b want 0", sa_ok); end
    bif.bus_req = 1'b1; bif.bus_idx = 3'd7;
    tick();
    bif.bus_req = 1'b0;
    n_cmp++; if (bif.bus_ack !== 1'b1 || bif.bus_data !== 8'h01) begin n_bad++; $display("FAIL bad_idx7 got ack %b data %h want ack 1 data 01", bif.bus_ack, bif.bus_data); end
    bif.flt_go = 1'b1;
    tick();
    bif.flt_go = 1'b0;
    tick();
    n_cmp++; if (bif.flt_valid !== 1'b1 || bif.flt_data !== 8'h08) begin n_bad++; $display("FAIL bad_stream got v %b data %h want v 1 data 08", bif.flt_valid, bif.flt_data); end
    for (int i = 0; i < 6; i++) tick();
  endtask

  initial begin
    rst = 1'b1;
    sarom_q = ROM_GOOD;
    ovr_we = 1'b0; ovr_widx = '0; ovr_wdata = '0; ovr_en = 1'b0;
    bif.bus_req = 1'b0; bif.bus_idx = '0; bif.flt_go = 1'b0;
    test_reset();
    test_bus();
    test_stream();
    test_arbitration();
    test_override();
    test_rst_mid_stream();
    test_bad_checksum();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
